// File: rtl/usb_endpoint_tx_packer_pkg.sv
// usbSpec: shared USB definitions used by the endpoint TX path.
package usbSpec;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/usb_tx_pkt_assembler.sv
// usb_tx_pkt_assembler: collects stream bytes into one packet and decides when it closes.
module usb_tx_pkt_assembler
  import usbSpec::*;
#(
  parameter int MAX_PKT       = 8,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_byteValid,
  output logic                          o_byteReady,
  input  logic [BYTE_W-1:0]             i_byte,
  input  logic                          i_flush,
  input  logic                          i_take,
  output logic                          o_full,
  output logic                          o_closePending,
  output logic [BYTE_W*MAX_PKT-1:0]     o_data,
  output logic [$clog2(MAX_PKT):0]      o_nBytes
);
  localparam int NBW = $clog2(MAX_PKT) + 1;
  localparam int TW  = FLUSH_TIMEOUT > 0 ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  logic [BYTE_W*MAX_PKT-1:0] data_q, data_d;
  logic [NBW-1:0]            nbytes_q, nbytes_d;
  logic                      pend_q, pend_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      accept;
  assign o_full         = nbytes_q == NBW'(MAX_PKT);
  assign o_byteReady    = !o_full && !pend_q;
  assign accept         = i_byteValid && o_byteReady;
  assign o_closePending = pend_q;
  assign o_data         = data_q;
  assign o_nBytes       = nbytes_q;
  // the idle timer only runs while a partial packet sits unclosed
  always_comb begin
    data_d   = data_q;
    nbytes_d = nbytes_q;
    pend_d   = pend_q;
    timer_d  = timer_q;
    if (i_take) begin
      data_d   = '0;
      nbytes_d = '0;
      pend_d   = 1'b0;
      timer_d  = '0;
    end else begin
      for (int k = 0; k < MAX_PKT; k++)
        if (accept && nbytes_q == NBW'(k)) data_d[k*BYTE_W +: BYTE_W] = i_byte;
      nbytes_d = nbytes_q + NBW'(accept);
      pend_d   = pend_q || (i_flush && !o_full);
      if (accept || nbytes_q == '0) timer_d = '0;
      else if (!pend_q && FLUSH_TIMEOUT > 0) begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(FLUSH_TIMEOUT - 1)) pend_d = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      data_q   <= '0;
      nbytes_q <= '0;
      pend_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      pend_q   <= pend_d;
      timer_q  <= timer_d;
    end
endmodule

// File: rtl/usb_endpoint_tx_packer.sv
// usb_endpoint_tx_packer: double-buffered byte-to-packet packer feeding the endpoint TX port.
module usb_endpoint_tx_packer
  import usbSpec::*;
#(
  parameter int MAX_PKT       = 8,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_halt,
  output logic                      o_etStall,
  input  logic                      i_byteValid,
  output logic                      o_byteReady,
  input  logic [BYTE_W-1:0]         i_byte,
  input  logic                      i_flush,
  input  logic                      i_etReady,
  output logic                      o_etValid,
  output logic [BYTE_W*MAX_PKT-1:0] o_etData,
  output logic [$clog2(MAX_PKT):0]  o_etData_nBytes,
  output logic                      o_idle
);
  localparam int NBW = $clog2(MAX_PKT) + 1;
  logic                      asm_full, asm_pend, take, deq;
  logic [BYTE_W*MAX_PKT-1:0] asm_data;
  logic [NBW-1:0]            asm_nbytes;
  logic                      out_valid_q, out_valid_d, stall_q, stall_d;
  logic [BYTE_W*MAX_PKT-1:0] out_data_q, out_data_d;
  logic [NBW-1:0]            out_nbytes_q, out_nbytes_d;
  usb_tx_pkt_assembler #(.MAX_PKT(MAX_PKT), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)) u_asm (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_byteValid    (i_byteValid),
    .o_byteReady    (o_byteReady),
    .i_byte         (i_byte),
    .i_flush        (i_flush),
    .i_take         (take),
    .o_full         (asm_full),
    .o_closePending (asm_pend),
    .o_data         (asm_data),
    .o_nBytes       (asm_nbytes)
  );
  // a stalled handshake is not a dequeue, so the packet is held until halt clears
  assign deq  = i_etReady && out_valid_q && !stall_q;
  assign take = (asm_full || asm_pend) && (!out_valid_q || deq);
  always_comb begin
    out_valid_d  = take || (out_valid_q && !deq);
    out_data_d   = take ? asm_data : deq ? '0 : out_data_q;
    out_nbytes_d = take ? asm_nbytes : deq ? '0 : out_nbytes_q;
    stall_d      = i_halt;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_nbytes_q <= out_nbytes_d;
      stall_q      <= stall_d;
    end
  assign o_etValid       = out_valid_q;
  assign o_etData        = out_data_q;
  assign o_etData_nBytes = out_nbytes_q;
  assign o_etStall       = stall_q;
  assign o_idle          = !out_valid_q && asm_nbytes == '0 && !asm_pend;
endmodule

// File: tb/tb_usb_endpoint_tx_packer.sv
// tb_usb_endpoint_tx_packer: scoreboard bench with a queue-based packet model of the packer.
module tb_usb_endpoint_tx_packer;
  localparam int MP = 8;
  localparam int FT = 4;
  logic clk = 0, rst = 0, halt = 0, bv = 0, flush = 0, er = 0;
  logic [7:0]  b = 0;
  logic        o_etStall, o_byteReady, o_etValid, o_idle;
  logic [63:0] o_etData;
  logic [3:0]  o_etData_nBytes;
  typedef struct packed {logic [63:0] d; logic [31:0] n;} pkt_t;
  pkt_t       exp_q[$];
  logic [7:0] m_asm[$];
  logic [7:0] sent_q[$];
  bit         m_pend, m_ov, m_stall;
  int         m_timer;
  pkt_t       m_out;
  int         errors = 0, checks = 0, delivered = 0;
  pkt_t        mon_p;
  logic [63:0] mon_sp;

  usb_endpoint_tx_packer #(.MAX_PKT(MP), .FLUSH_TIMEOUT(FT)) dut (
    .i_clk(clk), .i_rst(rst), .i_halt(halt), .o_etStall(o_etStall),
    .i_byteValid(bv), .o_byteReady(o_byteReady), .i_byte(b), .i_flush(flush),
    .i_etReady(er), .o_etValid(o_etValid), .o_etData(o_etData),
    .o_etData_nBytes(o_etData_nBytes), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic pkt_t asm_pkt();
    pkt_t p;
    p = '0;
    p.n = m_asm.size();
    foreach (m_asm[i]) p.d[i*8 +: 8] = m_asm[i];
    return p;
  endfunction

  // one clock of the packet model: bytes fill a queue, a packet closes when
  // full, flushed or idle too long, and moves out once the output slot is free
  task automatic model_step();
    int n;
    bit full, acc, deq, mv, old_pend;
    if (rst) begin
      m_asm.delete(); sent_q.delete(); exp_q.delete();
      m_pend = 0; m_timer = 0; m_ov = 0; m_out = '0; m_stall = 0;
      return;
    end
    n = m_asm.size();
    full = n == MP;
    old_pend = m_pend;
    acc = bv && !full && !m_pend;
    deq = er && m_ov && !m_stall;
    mv = (full || m_pend) && (!m_ov || deq);
    m_stall = halt;
    if (mv) begin
      m_out = asm_pkt();
      exp_q.push_back(m_out);
      m_ov = 1; m_asm.delete(); m_pend = 0; m_timer = 0;
    end else begin
      if (deq) begin m_ov = 0; m_out = '0; end
      if (acc) begin m_asm.push_back(b); sent_q.push_back(b); end
      if (flush && !full) m_pend = 1;
      if (acc || n == 0) m_timer = 0;
      else if (!old_pend) begin
        if (m_timer == FT - 1) m_pend = 1;
        m_timer++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) if (!rst) begin
    check("byteReady", 64'(o_byteReady), 64'(m_asm.size() != MP && !m_pend));
    check("etValid", 64'(o_etValid), 64'(m_ov));
    check("idle", 64'(o_idle), 64'(!m_ov && m_asm.size() == 0 && !m_pend));
    check("etStall", 64'(o_etStall), 64'(m_stall));
    check("etData", o_etData, m_out.d);
    check("nBytes", 64'(o_etData_nBytes), 64'(m_out.n));
    if (o_etValid && er && !o_etStall) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pkt_unexpected: got nBytes %0d want no packet", o_etData_nBytes);
      end else begin
        mon_p = exp_q.pop_front();
        check("pkt_data", o_etData, mon_p.d);
        check("pkt_n", 64'(o_etData_nBytes), 64'(mon_p.n));
        mon_sp = '0;
        for (int k = 0; k < int'(o_etData_nBytes); k++)
          if (sent_q.size() != 0) mon_sp[k*8 +: 8] = sent_q.pop_front();
        check("stream_order", o_etData, mon_sp);
        delivered++;
      end
    end
  end

  task automatic expect_latency(input string nm, input int want);
    int c = 0;
    while (!o_etValid && c < 20) begin tick(); c++; end
    check(nm, 64'(c + 1), 64'(want));
  endtask

  task automatic drain();
    int c = 0;
    er = 1; halt = 0; bv = 0; flush = 0;
    while ((exp_q.size() != 0 || o_etValid || m_asm.size() != 0 || m_pend) && c < 60) begin tick(); c++; end
    check("drain_bound", 64'(c < 60), 64'(1));
  endtask

  task automatic send(input logic [7:0] v);
    bv = 1; b = v; tick(); bv = 0;
  endtask

  initial begin
    int d0, sent, cyc, p;
    #1 rst = 1;
    #1;
    check("rst_etValid", 64'(o_etValid), 64'(0));
    check("rst_etData", o_etData, 64'(0));
    check("rst_nBytes", 64'(o_etData_nBytes), 64'(0));
    check("rst_etStall", 64'(o_etStall), 64'(0));
    check("rst_byteReady", 64'(o_byteReady), 64'(1));
    check("rst_idle", 64'(o_idle), 64'(1));
    tick();
    rst = 0;
    // full packet, back-to-back bytes
    er = 1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    expect_latency("full_latency", 2);
    check("full_data", o_etData, 64'h0807060504030201);
    check("full_n", 64'(o_etData_nBytes), 64'(8));
    drain();
    // short packet closed by flush
    send(8'hAA); send(8'hBB); send(8'hCC);
    flush = 1; tick(); flush = 0;
    expect_latency("flush_latency", 2);
    check("flush_data", o_etData, 64'hCCBBAA);
    check("flush_n", 64'(o_etData_nBytes), 64'(3));
    drain();
    // zero-length packet; the second flush lands while the first is pending
    er = 0; d0 = delivered;
    flush = 1; tick(); tick(); flush = 0;
    check("zlp_valid", 64'(o_etValid), 64'(1));
    check("zlp_data", o_etData, 64'(0));
    check("zlp_n", 64'(o_etData_nBytes), 64'(0));
    tick(); tick(); tick();
    drain();
    check("zlp_count", 64'(delivered - d0), 64'(1));
    // idle timeout
    send(8'h5A); send(8'hA5);
    expect_latency("timeout_latency", FT + 2);
    check("timeout_n", 64'(o_etData_nBytes), 64'(2));
    drain();
    // back-pressure with two buffers full
    er = 0; sent = 0; cyc = 0; d0 = delivered;
    while (sent < 20 && cyc < 40) begin
      bv = 1; b = 8'(sent + 1); p = int'(o_byteReady); tick(); cyc++;
      if (p != 0) sent++;
    end
    bv = 0;
    check("bp_accepted", 64'(sent), 64'(16));
    check("bp_ready_low", 64'(o_byteReady), 64'(0));
    er = 1; cyc = 0;
    while (sent < 20 && cyc < 40) begin
      bv = 1; b = 8'(sent + 1); p = int'(o_byteReady); tick(); cyc++;
      if (p != 0) sent++;
    end
    bv = 0; flush = 1; tick(); flush = 0;
    drain();
    check("bp_packets", 64'(delivered - d0), 64'(3));
    // halt holds a pending packet
    er = 0;
    send(8'h11); send(8'h22);
    flush = 1; tick(); flush = 0; tick();
    halt = 1; tick(); er = 1; d0 = delivered;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_stall", 64'(o_etStall), 64'(1));
      check("halt_held", o_etData, 64'h2211);
    end
    halt = 0;
    drain();
    check("halt_once", 64'(delivered - d0), 64'(1));
    // randomized traffic
    for (int seg = 0; seg < 30; seg++) begin
      p = $urandom_range(7, 1);
      for (int i = 0; i < 50; i++) begin
        bv = ($urandom % 8) < p; b = 8'($urandom); flush = ($urandom % 24) == 0;
        er = ($urandom % 4) != 0; halt = ($urandom % 16) == 0;
        tick();
      end
    end
    halt = 0; bv = 0; flush = 1; tick(); flush = 0;
    drain();
    check("rand_sb_empty", 64'(exp_q.size()), 64'(0));
    // asynchronous reset mid-stream
    er = 0; halt = 1;
    for (int i = 0; i < 10; i++) send(8'(i + 40));
    #2 rst = 1;
    #1;
    check("mid_rst_etValid", 64'(o_etValid), 64'(0));
    check("mid_rst_etData", o_etData, 64'(0));
    check("mid_rst_nBytes", 64'(o_etData_nBytes), 64'(0));
    check("mid_rst_etStall", 64'(o_etStall), 64'(0));
    check("mid_rst_byteReady", 64'(o_byteReady), 64'(1));
    check("mid_rst_idle", 64'(o_idle), 64'(1));
    tick();
    rst = 0; halt = 0;
    send(8'h01); send(8'h02); send(8'h03);
    flush = 1; tick(); flush = 0;
    drain();
    check("final_sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/usb_endpoint_tx_packer.md
# usb_endpoint_tx_packer

Synthesizable device-side endpoint TX stage that sits directly upstream of the USB full-speed transaction layer's endpoint TX port. It packs a byte stream into packets of up to MAX_PKT bytes and presents them on the `etValid/etReady/etData/etData_nBytes` handshake. It double-buffers, so assembly continues while a packet waits for an IN token. It closes short packets on explicit flush or idle timeout, and drives the endpoint STALL indication.

## Interface
- MAX_PKT, 8, maximum packet payload in bytes (≥1).
- FLUSH_TIMEOUT, 64, idle cycles before a partial packet is closed automatically; 0 disables the timer.

- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_halt  in  1  endpoint halted (from control logic).
- o_etStall  out  1  registered copy of i_halt.
- i_byteValid  in  1  byte-stream valid.
- o_byteReady  out  1  byte-stream ready.
- i_byte  in  8  byte-stream data.
- i_flush  in  1  close current packet (pulse).
- i_etReady  in  1  transaction layer takes packet.
- o_etValid  out  1  packet available.
- o_etData  out  8*MAX_PKT  payload; byte k in bits [8k+7:8k]; bytes ≥ nBytes are zero.
- o_etData_nBytes  out  $clog2(MAX_PKT)+1  payload length, 0..MAX_PKT.
- o_idle  out  1  both buffers empty and no close pending.

## Operation
- Assembly buffer: `asm_data`, `asm_nBytes`, `closePending`. Output register: `out_valid`, `out_data`, `out_nBytes`.
- o_byteReady = (asm_nBytes != MAX_PKT) && !closePending.
- Byte accept (i_byteValid && o_byteReady): i_byte is written at index asm_nBytes, and asm_nBytes increments.
- `full` = asm_nBytes == MAX_PKT; no flag is needed.
- closePending is set by:
  - i_flush while not full and not already pending. With the buffer empty this gives a zero-length packet.
  - Timer expiry with asm_nBytes > 0.
- i_flush in the same cycle as a byte accept: the byte is included in the closing packet.
- i_flush while full or pending: no effect (merged).
- Move: when (full || closePending) && (!out_valid || dequeue), then out ← asm, asm_data ← 0, asm_nBytes ← 0, closePending ← 0. A move and a dequeue in the same cycle keep out_valid at 1.
- Dequeue = i_etReady && o_etValid && !o_etStall. On dequeue with no move, out_valid ← 0, and out_data and out_nBytes ← 0.
- Stalled handshake (i_etReady && o_etValid && o_etStall): the packet is retained unchanged, and it is delivered after the halt clears.
- Timer: counter width $clog2(FLUSH_TIMEOUT+1).
  - Cleared on byte accept, on move, and while asm_nBytes == 0.
  - Increments when asm_nBytes > 0 && !closePending && no accept.
  - When it increments from FLUSH_TIMEOUT-1, closePending is set.
- Outputs driven from registers: o_etValid = out_valid, o_etData = out_data, o_etData_nBytes = out_nBytes.
- o_idle = !out_valid && asm_nBytes == 0 && !closePending.

## Timing
- Reset values:
  - o_etValid = 0, o_etData = 0, o_etData_nBytes = 0, o_etStall = 0.
  - o_byteReady = 1 and o_idle = 1 (derived from the reset state).
  - Counter = 0, closePending = 0.
- Reset mid-operation discards all buffered data asynchronously.
- Latency when the MAX_PKTth byte is accepted in cycle N and the output is free:
  - full in N+1, move at the end of N+1, o_etValid in N+2.
- Latency when i_flush is asserted in cycle N: closePending in N+1, o_etValid in N+2.
- Timeout, with the last byte accepted in cycle N and no further activity: closePending in N+FLUSH_TIMEOUT+1, o_etValid in N+FLUSH_TIMEOUT+2.
- Back-pressure: when the output is occupied and asm is full, o_byteReady stays 0 until the cycle after the dequeue.
- o_etStall follows i_halt with 1-cycle latency.
- o_etData and o_etData_nBytes are stable while o_etValid && !dequeue.

## Structure
- Shared `usbSpec` package: add no new typedefs. MAX_PKT stays a module parameter. The nBytes width is computed locally as $clog2(MAX_PKT)+1.
- One sub-module, `usb_tx_pkt_assembler`, contains the assembly buffer, closePending and the flush timer. It exposes `full`/`closePending`, data, nBytes and a `take` input.
- The top level holds the output register, the stall register, the handshake logic and o_idle.
- Flops use asynchronous-reset dff macros.

## Test plan
- Reset, then 8 bytes 0x01..0x08 back-to-back with i_etReady=1 → one packet, o_etData=0x0807060504030201, nBytes=8, o_etValid rises 2 cycles after the 8th accept.
- 3 bytes 0xAA,0xBB,0xCC, then i_flush, with i_etReady=1 → packet 0xCCBBAA, nBytes=3, o_etValid 2 cycles after flush.
- i_flush with empty buffer → zero-length packet, o_etData=0, nBytes=0; a second flush while that packet waits adds no extra packet.
- FLUSH_TIMEOUT=4: 2 bytes, then idle → packet nBytes=2 with o_etValid exactly 6 cycles after the last accept.
- i_etReady=0, 20 bytes streamed → two packets buffered, o_byteReady drops with 4 bytes outstanding. Then i_etReady=1 → packets 1–8, 9–16, then 17–20 delivered after flush, no loss or reorder.
- i_halt=1 with a packet pending and i_etReady=1 for 5 cycles → o_etStall=1, packet retained. i_halt=0 → same packet dequeued once. Assert i_rst mid-stream → all outputs return to reset values immediately.
